bp_be_fe_queue_replay_buffer: RTL and testbench
===============================================

// Module: bp_be_fe_queue_replay_buffer
// PURPOSE
//  Parametrised replay FIFO between FE queue and BE scheduler; successor to single-entry FE-queue handoff.
//  Holds fetched packets until commit; rolls read pointer back to oldest uncommitted entry on replay.
//  Flush discards everything. Generalised in width, depth and commit/retire granularity.
// PARAMETERS
//  width_p       96  packet width in bits (fe_queue_width_lp at instantiation)
//  els_p         16  entries; power of two, >=2
//  commit_max_p  2   max entries retired per cycle via commit_cnt_i
// PORTS
//  clk_i         in   1                      clock, all state on rising edge
//  reset_n_i     in   1                      asynchronous, active-low reset
//  enq_data_i    in   width_p                packet from FE
//  enq_v_i       in   1                      enqueue valid
//  enq_ready_o   out  1                      space available (ready-then-valid)
//  deq_data_o    out  width_p                packet at read pointer
//  deq_v_o       out  1                      unread packet available
//  deq_yumi_i    in   1                      consumer takes deq_data_o (only when deq_v_o)
//  commit_cnt_i  in   $clog2(commit_max_p+1) oldest read entries to retire this cycle
//  roll_i        in   1                      rewind read pointer to commit pointer
//  flush_i       in   1                      discard all entries
//  occupancy_o   out  $clog2(els_p+1)        entries held (committed-pending + unread)
//  unread_o      out  $clog2(els_p+1)        entries between read and write pointer
// BEHAVIOUR
//  State: wptr, rptr, cptr, each $clog2(els_p)+1 bits (extra wrap bit); storage els_p x width_p regs.
//  Reset (reset_n_i low, async): all pointers 0; enq_ready_o=1 after release, 0 while held;
//   deq_v_o=0, deq_data_o=0, occupancy_o=0, unread_o=0. Storage not reset.
//  Invariant: cptr <= rptr <= wptr (modular); occupancy=wptr-cptr; unread=wptr-rptr.
//  enq_ready_o = (occupancy != els_p); enqueue fires on enq_v_i & enq_ready_o: mem[wptr]<=data, wptr++.
//  deq_v_o = (unread != 0); deq_data_o = mem[rptr], 0 when deq_v_o=0; yumi fires: rptr++.
//  Commit: cptr += commit_cnt_i; commit_cnt_i > (rptr-cptr) is illegal (assertion, cptr saturates at rptr).
//  Roll: rptr <= cptr_next (after same-cycle commit); yumi same cycle discarded; enqueue proceeds.
//  Flush: wptr,rptr,cptr <= 0; same-cycle enqueue, yumi, commit, roll all discarded.
//  Priority: flush > roll > {commit, yumi, enqueue} (latter three independent, concurrent).
//  Full: enq_ready_o=0 until commit frees an entry; freed slot usable next cycle (no same-cycle pass).
//  Empty (unread=0): deq_v_o=0 next cycle after last yumi; enqueue visible at deq one cycle later.
//  Wrap: pointers wrap at 2*els_p; index = low bits; full/empty disambiguated by wrap bit.
//  Latency: enqueue-to-deq 1 cycle (0 with bypass, see below); roll-to-deq 1 cycle.
//  Reset mid-operation: all in-flight state dropped immediately; no output glitch beyond reset values.
//  Outputs occupancy_o/unread_o are registered-pointer differences (reflect state, not same-cycle events).
// CONFIGURATION
//  BP_BE_FE_QUEUE_BYPASS_EN defined: when unread=0 and enq fires, deq_v_o=1 and deq_data_o=enq_data_i
//   same cycle; a same-cycle yumi advances rptr with wptr; entry still written, remains rollable.
//   Bypass suppressed when roll_i or flush_i asserted.
//  Not defined: no combinational enq->deq path; 1-cycle minimum latency.
// TESTING
//  Reset: hold reset_n_i low 3 cycles -> deq_v_o=0, occupancy_o=0; release -> enq_ready_o=1.
//  Fill: els_p=16, enqueue 16 pkts, no commit -> enq_ready_o=0 at occupancy 16; commit 1 -> ready=1 next cycle.
//  Replay: enq A,B,C; yumi A,B; commit 1; roll -> deq_data_o=B next cycle, unread_o=2.
//  Roll+yumi+commit same cycle with 3 read, commit_cnt_i=2 -> rptr=cptr+2, yumi dropped, deq shows 3rd pkt.
//  Flush with enq_v_i high and 10 entries -> next cycle occupancy_o=0, deq_v_o=0, enqueued pkt lost.
//  Wrap: stream 100 pkts, yumi+commit each cycle -> in-order data, no stall; bypass build: 0-cycle deq.

Source files
------------

// File: rtl/bp_be_fe_queue_replay_buffer.sv
// bp_be_fe_queue_replay_buffer
//   Replay FIFO between the FE queue and the BE scheduler. Fetched packets
//   stay in storage until the backend commits them. A roll rewinds the read
//   pointer to the oldest uncommitted entry so those packets are delivered
//   again. A flush discards every entry.
//
//   Three pointers (write, read, commit) each carry one extra wrap bit, so
//   "full" and "empty" can be told apart without a separate counter.
//   Outside reset they keep the ordering commit <= read <= write (modular).
//
// Ports
//   clk_i         clock; all state updates on the rising edge
//   reset_n_i     asynchronous active-low reset
//   enq_data_i    packet from FE
//   enq_v_i       enqueue valid
//   enq_ready_o   space available; low while reset is held
//   deq_data_o    packet at the read pointer; zero when deq_v_o is low
//   deq_v_o       an unread packet is available
//   deq_yumi_i    consumer takes deq_data_o; only legal with deq_v_o high
//   commit_cnt_i  number of oldest read entries retired this cycle
//   roll_i        rewind the read pointer to the commit pointer
//   flush_i       discard all entries
//   occupancy_o   entries held, committed-pending plus unread
//   unread_o      entries between the read and write pointers
//
// Build option
//   BP_BE_FE_QUEUE_BYPASS_EN: if no packet is unread, an enqueue is shown on
//   deq in the same cycle. The packet is still written to storage so it
//   stays rollable.

module bp_be_fe_queue_replay_buffer #(
  parameter int width_p      = 96,
  parameter int els_p        = 16,
  parameter int commit_max_p = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [width_p-1:0]                enq_data_i,
  input  logic                              enq_v_i,
  output logic                              enq_ready_o,
  output logic [width_p-1:0]                deq_data_o,
  output logic                              deq_v_o,
  input  logic                              deq_yumi_i,
  input  logic [$clog2(commit_max_p+1)-1:0] commit_cnt_i,
  input  logic                              roll_i,
  input  logic                              flush_i,
  output logic [$clog2(els_p+1)-1:0]        occupancy_o,
  output logic [$clog2(els_p+1)-1:0]        unread_o
);

  localparam int idx_w = $clog2(els_p);
  localparam int ptr_w = idx_w + 1;
  localparam int cnt_w = $clog2(els_p + 1);
  localparam int cc_w  = $clog2(commit_max_p + 1);

  logic [ptr_w-1:0]   wptr, rptr, cptr;
  logic [ptr_w-1:0]   wptr_n, rptr_n, cptr_n;
  logic [ptr_w-1:0]   occ, unread, read_pend;
  logic               live;
  logic               enq_fire, yumi_fire, bypass, has_unread;
  logic [width_p-1:0] mem [els_p];

  // Retire no more than the entries that have already been read. A larger
  // request is illegal; clamping it keeps the pointer ordering intact.
  function automatic logic [ptr_w-1:0] sat_commit(input logic [cc_w-1:0]  cnt,
                                                  input logic [ptr_w-1:0] avail);
    logic [ptr_w-1:0] req;
    req = ptr_w'(cnt);
    return (req > avail) ? avail : req;
  endfunction

  assign occ        = wptr - cptr;
  assign unread     = wptr - rptr;
  assign read_pend  = rptr - cptr;
  assign has_unread = (unread != '0);

  // live is a flop cleared by reset, so enqueue stays blocked while reset is held.
  assign enq_ready_o = live & (occ != ptr_w'(els_p));
  assign enq_fire    = enq_v_i & enq_ready_o;

`ifdef BP_BE_FE_QUEUE_BYPASS_EN
  assign bypass = enq_fire & ~has_unread & ~roll_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign deq_v_o    = has_unread | bypass;
  assign deq_data_o = has_unread ? mem[rptr[idx_w-1:0]] :
                      (bypass ? enq_data_i : '0);
  assign yumi_fire  = deq_yumi_i & deq_v_o;

  assign occupancy_o = cnt_w'(occ);
  assign unread_o    = cnt_w'(unread);

  // Pointer updates. Precedence is flush, then roll, then the independent
  // commit/yumi/enqueue. Roll rewinds to the commit pointer as it stands
  // after this cycle's commit, and discards a same-cycle yumi.
  always_comb begin
    wptr_n = enq_fire ? wptr + ptr_w'(1) : wptr;
    cptr_n = cptr + sat_commit(commit_cnt_i, read_pend);
    rptr_n = yumi_fire ? rptr + ptr_w'(1) : rptr;
    if (roll_i) begin
      rptr_n = cptr_n;
    end
    if (flush_i) begin
      wptr_n = '0;
      rptr_n = '0;
      cptr_n = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
      live <= 1'b0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
      live <= 1'b1;
    end
  end

  // Storage is not reset. The pointers alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (enq_fire && !flush_i) begin
      mem[wptr[idx_w-1:0]] <= enq_data_i;
    end
  end

  commit_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    flush_i || (ptr_w'(commit_cnt_i) <= read_pend));

endmodule

// File: tb/tb_bp_be_fe_queue_replay_buffer.sv
module tb_bp_be_fe_queue_replay_buffer;

  localparam int W   = 96;
  localparam int ELS = 16;
  localparam int CM  = 2;
  localparam int CW  = $clog2(CM + 1);
  localparam int NW  = $clog2(ELS + 1);
`ifdef BP_BE_FE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  enq_data;
  logic          enq_v;
  logic          enq_ready;
  logic [W-1:0]  deq_data;
  logic          deq_v;
  logic          deq_yumi;
  logic [CW-1:0] commit_cnt;
  logic          roll;
  logic          flush;
  logic [NW-1:0] occupancy;
  logic [NW-1:0] unread;

  bp_be_fe_queue_replay_buffer #(.width_p(W), .els_p(ELS), .commit_max_p(CM)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .enq_data_i(enq_data), .enq_v_i(enq_v), .enq_ready_o(enq_ready),
    .deq_data_o(deq_data), .deq_v_o(deq_v), .deq_yumi_i(deq_yumi),
    .commit_cnt_i(commit_cnt), .roll_i(roll), .flush_i(flush),
    .occupancy_o(occupancy), .unread_o(unread)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           v;
    bit           rdy;
    int           occ;
    int           unr;
    logic [W-1:0] data;
  } exp_t;

  exp_t         stat_q[$];   // per-cycle expected status
  logic [W-1:0] data_q[$];   // expected packets, in consumption order

  // Reference model: the retained packets, oldest first, and how many of
  // them the consumer has already taken.
  logic [W-1:0] model_q[$];
  int           rd;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: pops the expected status each cycle, and an expected packet
  // whenever the DUT hands one over.
  always @(negedge clk) begin
    if (reset_n && stat_q.size() > 0) begin
      exp_t e;
      e = stat_q.pop_front();
      chk("deq_v", 128'(deq_v), 128'(e.v));
      chk("enq_ready", 128'(enq_ready), 128'(e.rdy));
      chk("occupancy", 128'(occupancy), 128'(e.occ));
      chk("unread", 128'(unread), 128'(e.unr));
      chk("deq_data", 128'(deq_data), 128'(e.data));
      if (deq_v && deq_yumi) begin
        if (data_q.size() == 0) begin
          chk("unexpected_deq", 128'(1), 128'(0));
        end else begin
          chk("sb_data", 128'(deq_data), 128'(data_q.pop_front()));
        end
      end
    end
  end

  function automatic logic [W-1:0] rnd_pkt();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Drives one cycle of stimulus and records what the DUT should show
  // during that cycle. The model is then advanced past the clock edge.
  task automatic cycle(input bit ev, input logic [W-1:0] d, input bit y,
                       input int cc, input bit rl, input bit fl);
    exp_t e;
    int   unr, c;
    bit   efire, byp, yfire;
    unr   = model_q.size() - rd;
    efire = ev && (model_q.size() < ELS);
    byp   = BYP && (unr == 0) && efire && !rl && !fl;
    e.v   = (unr != 0) || byp;
    e.rdy = model_q.size() < ELS;
    e.occ = model_q.size();
    e.unr = unr;
    e.data = (unr != 0) ? model_q[rd] : (byp ? d : '0);
    yfire = y && e.v;
    c     = (cc > rd) ? rd : cc;
    enq_v      = ev;
    enq_data   = d;
    deq_yumi   = yfire;
    commit_cnt = CW'(c);
    roll       = rl;
    flush      = fl;
    stat_q.push_back(e);
    if (yfire) data_q.push_back(e.data);
    if (fl) begin
      model_q.delete();
      rd = 0;
    end else begin
      repeat (c) void'(model_q.pop_front());
      rd -= c;
      if (efire) model_q.push_back(d);
      if (rl) rd = 0;
      else if (yfire) rd++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] pa, pb, pc;
    reset_n    = 1'b0;
    enq_v      = 1'b0;
    enq_data   = '0;
    deq_yumi   = 1'b0;
    commit_cnt = '0;
    roll       = 1'b0;
    flush      = 1'b0;
    rd         = 0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_deq_v", 128'(deq_v), 128'(0));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_unread", 128'(unread), 128'(0));
    chk("rst_deq_data", 128'(deq_data), 128'(0));
    chk("rst_enq_ready_held", 128'(enq_ready), 128'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_enq_ready_release", 128'(enq_ready), 128'(1));

    // Fill to capacity, stall, then free one slot through read + commit
    for (int i = 0; i < ELS; i++) cycle(1'b1, rnd_pkt(), 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, rnd_pkt(), 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 0, 1'b0, 1'b0);
    cycle(1'b1, rnd_pkt(), 1'b0, 1, 1'b0, 1'b0);
    cycle(1'b1, rnd_pkt(), 1'b0, 0, 1'b0, 1'b0);
    idle();
    cycle(1'b0, '0, 1'b0, 0, 1'b0, 1'b1);

    // Replay: A,B,C in; read A,B; commit one; roll; B is shown again
    pa = rnd_pkt(); pb = rnd_pkt(); pc = rnd_pkt();
    cycle(1'b1, pa, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, pb, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, pc, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 0, 1'b1, 1'b0);
    idle();
    chk("replay_deq_b", 128'(deq_data), 128'(pb));
    chk("replay_unread", 128'(unread), 128'(2));
    cycle(1'b0, '0, 1'b0, 0, 1'b0, 1'b1);

    // Roll, yumi and commit of two in the same cycle after three reads
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd_pkt(), 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 2, 1'b1, 1'b0);
    idle();
    cycle(1'b0, '0, 1'b0, 0, 1'b0, 1'b1);

    // Flush with ten entries and a same-cycle enqueue
    for (int i = 0; i < 10; i++) cycle(1'b1, rnd_pkt(), (i % 3) == 0, 0, 1'b0, 1'b0);
    cycle(1'b1, rnd_pkt(), 1'b1, 1, 1'b0, 1'b1);
    idle();

    // Streaming across many pointer wraps with read and commit every cycle
    for (int i = 0; i < 100; i++) cycle(1'b1, rnd_pkt(), 1'b1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 2, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 99) < 60, rnd_pkt(), $urandom_range(0, 99) < 55,
            int'($urandom_range(0, CM)), $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 2);
    end

    // Reset in the middle of traffic
    for (int i = 0; i < 6; i++) cycle(1'b1, rnd_pkt(), 1'b0, 0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_deq_v", 128'(deq_v), 128'(0));
    chk("midrst_occupancy", 128'(occupancy), 128'(0));
    chk("midrst_unread", 128'(unread), 128'(0));
    chk("midrst_enq_ready", 128'(enq_ready), 128'(0));
    chk("midrst_deq_data", 128'(deq_data), 128'(0));
    model_q.delete();
    rd = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) cycle(1'b1, rnd_pkt(), 1'b1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 2, 1'b0, 1'b0);

    idle();
    chk("sb_stat_drained", 128'(stat_q.size()), 128'(0));
    chk("sb_data_drained", 128'(data_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
